// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state codes, frame size and keyboard command bytes.
// Used by both the host transmitter and the keyboard receiver.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_SEND      = 3'd2;
  localparam logic [2:0] ST_ACK       = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pads plus a clock falling-edge pulse.
// Idle PS/2 lines are high, so all flops reset to 1 to avoid a spurious edge after reset.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall_c
);

  logic clk_meta;
  logic clk_prev;
  logic data_meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  assign clk_fall_c = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, start, 8 data bits LSB-first, odd parity,
// stop and device ACK, with an inter-edge timeout. Both lines are driven only via open-drain OEs.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_busy,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe,
  output logic       o_tx_done,
  output logic       o_tx_ack_err,
  output logic       o_tx_timeout
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                      : INHIBIT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [3:0]  LAST_TX_BIT = 4'(PS2_FRAME_BITS - 2);

  logic             clk_sync;
  logic             data_sync;
  logic             clk_fall_c;

  logic [2:0]       state,    state_nxt;
  logic [CNT_W-1:0] cnt,      cnt_nxt;
  logic [3:0]       bit_cnt,  bit_cnt_nxt;
  logic [9:0]       frame,    frame_nxt;
  logic             ack_bad,  ack_bad_nxt;
  logic             clk_oe_nxt;
  logic             data_oe_nxt;
  logic             done_nxt;
  logic             ack_err_nxt;
  logic             timeout_nxt;
  logic             ready_nxt;
  logic             timed_out_c;

  ps2_line_sync u_sync (
    .clk        (i_clk),
    .rst        (i_rst),
    .ps2_clk    (i_ps2_clk),
    .ps2_data   (i_ps2_data),
    .clk_sync   (clk_sync),
    .data_sync  (data_sync),
    .clk_fall_c (clk_fall_c)
  );

  assign timed_out_c = (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state and next-output logic; the counter doubles as inhibit timer and edge timeout.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    frame_nxt   = frame;
    ack_bad_nxt = ack_bad;
    clk_oe_nxt  = o_ps2_clk_oe;
    data_oe_nxt = o_ps2_data_oe;
    done_nxt    = 1'b0;
    ack_err_nxt = o_tx_ack_err;
    timeout_nxt = o_tx_timeout;

    case (state)
      ST_IDLE: begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        if (i_tx_valid && o_tx_ready) begin
          frame_nxt   = {1'b1, ~^i_tx_data, i_tx_data};
          cnt_nxt     = '0;
          bit_cnt_nxt = '0;
          ack_bad_nxt = 1'b0;
          clk_oe_nxt  = 1'b1;
          state_nxt   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_W'(INHIBIT_CYCLES - 2)) begin
          data_oe_nxt = 1'b1;
        end
        if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
          clk_oe_nxt = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = ST_SEND;
        end
      end

      ST_SEND: begin
        cnt_nxt = cnt + 1'b1;
        if (clk_fall_c) begin
          cnt_nxt     = '0;
          data_oe_nxt = ~frame[bit_cnt];
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == LAST_TX_BIT) begin
            state_nxt = ST_ACK;
          end
        end else if (timed_out_c) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_ACK: begin
        cnt_nxt = cnt + 1'b1;
        if (clk_fall_c) begin
          cnt_nxt     = '0;
          ack_bad_nxt = data_sync;
          state_nxt   = ST_WAIT_IDLE;
        end else if (timed_out_c) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        cnt_nxt = cnt + 1'b1;
        if (clk_sync && data_sync) begin
          done_nxt    = 1'b1;
          ack_err_nxt = ack_bad;
          timeout_nxt = 1'b0;
          state_nxt   = ST_IDLE;
        end else if (timed_out_c) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        state_nxt   = ST_IDLE;
      end
    endcase

    // Timeout abort shares one exit path for SEND, ACK and WAIT_IDLE.
    if ((state == ST_SEND || state == ST_ACK || state == ST_WAIT_IDLE) &&
        state_nxt == ST_IDLE && !done_nxt) begin
      clk_oe_nxt  = 1'b0;
      data_oe_nxt = 1'b0;
      done_nxt    = 1'b1;
      ack_err_nxt = 1'b0;
      timeout_nxt = 1'b1;
    end

    ready_nxt = (state_nxt == ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      frame         <= '0;
      ack_bad       <= 1'b0;
      o_tx_ready    <= 1'b1;
      o_busy        <= 1'b0;
      o_ps2_clk_oe  <= 1'b0;
      o_ps2_data_oe <= 1'b0;
      o_tx_done     <= 1'b0;
      o_tx_ack_err  <= 1'b0;
      o_tx_timeout  <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bit_cnt       <= bit_cnt_nxt;
      frame         <= frame_nxt;
      ack_bad       <= ack_bad_nxt;
      o_tx_ready    <= ready_nxt;
      o_busy        <= ~ready_nxt;
      o_ps2_clk_oe  <= clk_oe_nxt;
      o_ps2_data_oe <= data_oe_nxt;
      o_tx_done     <= done_nxt;
      o_tx_ack_err  <= ack_err_nxt;
      o_tx_timeout  <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host; a scoreboard
// holds the expected frame and flags per request and is checked on every o_tx_done.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INHIBIT = 50;
  localparam int unsigned TIMEOUT = 2000;
  localparam int unsigned HALF    = 40;
  localparam int unsigned QTR     = 20;

  typedef struct {
    logic [9:0] frame;
    logic       ack_err;
    logic       timeout;
    logic       chk_frame;
  } exp_t;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_tx_data = 8'h00;
  logic       i_tx_valid = 1'b0;
  logic       o_tx_ready, o_busy, o_ps2_clk_oe, o_ps2_data_oe;
  logic       o_tx_done, o_tx_ack_err, o_tx_timeout;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  logic [9:0] obs_frame = '0;
  exp_t       sb[$];

  assign ps2_clk_line  = dev_clk & ~o_ps2_clk_oe;
  assign ps2_data_line = dev_data & ~o_ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_ps2_clk     (ps2_clk_line),
    .i_ps2_data    (ps2_data_line),
    .i_tx_data     (i_tx_data),
    .i_tx_valid    (i_tx_valid),
    .o_tx_ready    (o_tx_ready),
    .o_busy        (o_busy),
    .o_ps2_clk_oe  (o_ps2_clk_oe),
    .o_ps2_data_oe (o_ps2_data_oe),
    .o_tx_done     (o_tx_done),
    .o_tx_ack_err  (o_tx_ack_err),
    .o_tx_timeout  (o_tx_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  // Scoreboard pop on every completed transfer.
  always @(negedge clk) begin
    if (o_tx_done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check_eq("done_unexpected", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        check_eq("ack_err", 32'(o_tx_ack_err), 32'(e.ack_err));
        check_eq("timeout", 32'(o_tx_timeout), 32'(e.timeout));
        if (e.chk_frame) check_eq("frame", 32'(obs_frame), 32'(e.frame));
      end
    end
  end

  task automatic send_req(input logic [7:0] d, input logic push, input logic exp_ack,
                          input logic exp_tmo);
    int n = 0;
    exp_t e;
    @(negedge clk);
    i_tx_valid = 1'b1;
    i_tx_data  = d;
    while (!o_tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", 32'(n < 5000), 32'(1));
    e.frame = frame_of(d);
    e.ack_err = exp_ack;
    e.timeout = exp_tmo;
    e.chk_frame = ~exp_tmo;
    if (push) sb.push_back(e);
    @(negedge clk);
    i_tx_valid = 1'b0;
    check_eq("accept_busy", 32'(o_busy), 32'(1));
    check_eq("accept_ready", 32'(o_tx_ready), 32'(0));
    check_eq("accept_clk_oe", 32'(o_ps2_clk_oe), 32'(1));
    check_eq("accept_data_oe", 32'(o_ps2_data_oe), 32'(0));
  endtask

  // Device model: measures the inhibit, then clocks `falls` edges, sampling on rising edges.
  task automatic dev_xfer(input logic do_ack, input int falls);
    int n = 0;
    int inh = 0;
    int start = 0;
    while (!o_ps2_clk_oe && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("dev_saw_inhibit", 32'(n < 5000), 32'(1));
    while (o_ps2_clk_oe && inh < 10000) begin
      inh++;
      if (o_ps2_data_oe) start++;
      @(negedge clk);
    end
    check_eq("inhibit_len", 32'(inh), 32'(INHIBIT));
    check_eq("start_overlap", 32'(start), 32'(1));
    check_eq("start_bit", 32'(ps2_data_line), 32'(0));
    repeat (QTR) @(negedge clk);
    for (int f = 1; f <= 11; f++) begin
      if (f > falls) break;
      if (f == 11) begin
        if (do_ack) dev_data = 1'b0;
        repeat (QTR) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (f <= 10) obs_frame[f-1] = ps2_data_line;
      repeat (HALF) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input int start_cnt, input int budget, output int n);
    n = 0;
    while (done_cnt == start_cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", 32'(done_cnt != start_cnt), 32'(1));
  endtask

  task automatic full_xfer(input logic [7:0] d, input logic do_ack);
    int d0 = done_cnt;
    int n;
    fork
      send_req(d, 1'b1, ~do_ack, 1'b0);
      dev_xfer(do_ack, 11);
    join
    wait_done(d0, 500, n);
  endtask

  initial begin
    int n;
    int d0;
    int stray;

    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 32'(o_tx_ready), 32'(1));
    check_eq("rst_busy", 32'(o_busy), 32'(0));
    check_eq("rst_clk_oe", 32'(o_ps2_clk_oe), 32'(0));
    check_eq("rst_data_oe", 32'(o_ps2_data_oe), 32'(0));
    check_eq("rst_done", 32'(o_tx_done), 32'(0));
    check_eq("rst_flags", 32'({o_tx_ack_err, o_tx_timeout}), 32'(0));

    full_xfer(PS2_CMD_SET_LED, 1'b1);
    check_eq("ed_bits", 32'(obs_frame), 32'(10'b11_1110_1101));

    full_xfer(8'h01, 1'b1);
    check_eq("parity_01", 32'(obs_frame[8]), 32'(0));

    full_xfer(PS2_CMD_RESET, 1'b1);
    check_eq("parity_ff", 32'(obs_frame[8]), 32'(1));

    full_xfer(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    check_eq("ack_err_hold", 32'(o_tx_ack_err), 32'(1));

    // Device stops after bit 3; counter restarted at fall 4, model returns 2*HALF later.
    d0 = done_cnt;
    fork
      send_req(8'hA5, 1'b1, 1'b0, 1'b1);
      dev_xfer(1'b1, 4);
    join
    wait_done(d0, TIMEOUT + 1000, n);
    check_eq("timeout_latency",
             32'((n >= int'(TIMEOUT - 2*HALF) - 10) && (n <= int'(TIMEOUT - 2*HALF) + 10)),
             32'(1));
    check_eq("tmo_clk_oe", 32'(o_ps2_clk_oe), 32'(0));
    check_eq("tmo_data_oe", 32'(o_ps2_data_oe), 32'(0));
    check_eq("tmo_ready", 32'(o_tx_ready), 32'(1));

    // Reset after bit 5 is presented.
    d0 = done_cnt;
    fork
      send_req(8'h12, 1'b0, 1'b0, 1'b0);
      dev_xfer(1'b1, 6);
    join
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check_eq("mid_rst_clk_oe", 32'(o_ps2_clk_oe), 32'(0));
    check_eq("mid_rst_data_oe", 32'(o_ps2_data_oe), 32'(0));
    check_eq("mid_rst_ready", 32'(o_tx_ready), 32'(1));
    check_eq("mid_rst_busy", 32'(o_busy), 32'(0));
    repeat (TIMEOUT + 100) @(negedge clk);
    check_eq("mid_rst_no_done", 32'(done_cnt), 32'(d0));
    full_xfer(PS2_CMD_ENABLE, 1'b1);

    // Second request held valid while the first is still in flight.
    d0 = done_cnt;
    fork
      begin
        send_req(8'h3C, 1'b1, 1'b0, 1'b0);
        send_req(8'hAA, 1'b1, 1'b0, 1'b0);
      end
      begin
        dev_xfer(1'b1, 11);
        dev_xfer(1'b1, 11);
      end
    join
    wait_done(d0 + 1, 500, n);
    stray = 0;
    repeat (500) begin
      @(negedge clk);
      if (o_ps2_clk_oe) stray++;
    end
    check_eq("held_done_count", 32'(done_cnt - d0), 32'(2));
    check_eq("held_no_resend", 32'(stray), 32'(0));
    check_eq("sb_empty", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
